// File: rtl/id_ex_if.sv
// ID-to-EX pipeline bus: decoded ID fields and stage controls in, registered EX fields and hazard status out.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 4,
  parameter int MEM_W  = 5,
  parameter int CNT_W  = 16
);
  logic              Stall;
  logic              Flush;
  logic              ID_Valid;
  logic [WB_W-1:0]   ID_WB_Ctrl;
  logic [MEM_W-1:0]  ID_MEM_Ctrl;
  logic [8:0]        ID_EX_Ctrl;
  logic [DATA_W-1:0] ID_PCAddResult;
  logic [DATA_W-1:0] ID_Read1;
  logic [DATA_W-1:0] ID_Read2;
  logic [DATA_W-1:0] ID_SignExtend;
  logic [DATA_W-1:0] ID_SignExtend_10_6;
  logic [REG_W-1:0]  ID_Rs;
  logic [REG_W-1:0]  ID_Rt;
  logic [REG_W-1:0]  ID_Rd;

  logic [WB_W-1:0]   EX_WBCtrl;
  logic [MEM_W-1:0]  EX_MEMCtrl;
  logic [1:0]        EX_RegDst;
  logic              EX_ALUSrc;
  logic [3:0]        EX_ALUOp;
  logic [1:0]        EX_HalfByte;
  logic              EX_Valid;
  logic [DATA_W-1:0] EX_PCAddResult;
  logic [DATA_W-1:0] EX_Read1;
  logic [DATA_W-1:0] EX_Read2;
  logic [DATA_W-1:0] EX_SignExtend;
  logic [DATA_W-1:0] EX_SignExtend_10_6;
  logic [REG_W-1:0]  EX_Rs;
  logic [REG_W-1:0]  EX_Rt;
  logic [REG_W-1:0]  EX_Rd;
  logic              HazardStall;
  logic [CNT_W-1:0]  BubbleCount;

  modport master (
    output Stall, Flush, ID_Valid, ID_WB_Ctrl, ID_MEM_Ctrl, ID_EX_Ctrl,
           ID_PCAddResult, ID_Read1, ID_Read2, ID_SignExtend, ID_SignExtend_10_6,
           ID_Rs, ID_Rt, ID_Rd,
    input  EX_WBCtrl, EX_MEMCtrl, EX_RegDst, EX_ALUSrc, EX_ALUOp, EX_HalfByte, EX_Valid,
           EX_PCAddResult, EX_Read1, EX_Read2, EX_SignExtend, EX_SignExtend_10_6,
           EX_Rs, EX_Rt, EX_Rd, HazardStall, BubbleCount
  );

  modport slave (
    input  Stall, Flush, ID_Valid, ID_WB_Ctrl, ID_MEM_Ctrl, ID_EX_Ctrl,
           ID_PCAddResult, ID_Read1, ID_Read2, ID_SignExtend, ID_SignExtend_10_6,
           ID_Rs, ID_Rt, ID_Rd,
    output EX_WBCtrl, EX_MEMCtrl, EX_RegDst, EX_ALUSrc, EX_ALUOp, EX_HalfByte, EX_Valid,
           EX_PCAddResult, EX_Read1, EX_Read2, EX_SignExtend, EX_SignExtend_10_6,
           EX_Rs, EX_Rt, EX_Rd, HazardStall, BubbleCount
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush, stall, load-use bubble insertion and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int WB_W        = 4,
  parameter int MEM_W       = 5,
  parameter int MEMREAD_BIT = 0,
  parameter int CNT_W       = 16
) (
  input logic     Clk,
  input logic     Rst_n,
  id_ex_if.slave  bus
);

  logic              r_valid;
  logic [WB_W-1:0]   r_wb;
  logic [MEM_W-1:0]  r_mem;
  logic [8:0]        r_exctl;
  logic [DATA_W-1:0] r_pc, r_read1, r_read2, r_sext, r_sext_10_6;
  logic [REG_W-1:0]  r_rs, r_rt, r_rd;
  logic [CNT_W-1:0]  r_bubbles;

  logic w_hazard, w_bubble, w_kill, w_load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A load in EX whose destination feeds the instruction in ID must wait one cycle.
  assign w_hazard = r_valid && r_mem[MEMREAD_BIT] && bus.ID_Valid && (r_rt != '0) &&
                    ((r_rt == bus.ID_Rs) || (r_rt == bus.ID_Rt));
  assign w_bubble = !bus.Flush && !bus.Stall && w_hazard;
  assign w_kill   = bus.Flush || w_bubble;
  assign w_load   = !bus.Flush && !bus.Stall && !w_hazard;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_valid     <= 1'b0;
      r_wb        <= '0;
      r_mem       <= '0;
      r_exctl     <= '0;
      r_pc        <= '0;
      r_read1     <= '0;
      r_read2     <= '0;
      r_sext      <= '0;
      r_sext_10_6 <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_bubbles   <= '0;
    end else begin
      // Squashed slots keep their datapath values; only control is cleared.
      if (w_kill) begin
        r_valid <= 1'b0;
        r_wb    <= '0;
        r_mem   <= '0;
        r_exctl <= '0;
      end else if (w_load) begin
        r_valid     <= bus.ID_Valid;
        r_wb        <= bus.ID_Valid ? bus.ID_WB_Ctrl  : '0;
        r_mem       <= bus.ID_Valid ? bus.ID_MEM_Ctrl : '0;
        r_exctl     <= bus.ID_Valid ? bus.ID_EX_Ctrl  : '0;
        r_pc        <= bus.ID_PCAddResult;
        r_read1     <= bus.ID_Read1;
        r_read2     <= bus.ID_Read2;
        r_sext      <= bus.ID_SignExtend;
        r_sext_10_6 <= bus.ID_SignExtend_10_6;
        r_rs        <= bus.ID_Rs;
        r_rt        <= bus.ID_Rt;
        r_rd        <= bus.ID_Rd;
      end
      if (w_bubble) r_bubbles <= sat_inc(r_bubbles);
    end
  end

  assign bus.EX_Valid           = r_valid;
  assign bus.EX_WBCtrl          = r_wb;
  assign bus.EX_MEMCtrl         = r_mem;
  assign bus.EX_RegDst          = r_exctl[1:0];
  assign bus.EX_ALUSrc          = r_exctl[2];
  assign bus.EX_ALUOp           = r_exctl[6:3];
  assign bus.EX_HalfByte        = r_exctl[8:7];
  assign bus.EX_PCAddResult     = r_pc;
  assign bus.EX_Read1           = r_read1;
  assign bus.EX_Read2           = r_read2;
  assign bus.EX_SignExtend      = r_sext;
  assign bus.EX_SignExtend_10_6 = r_sext_10_6;
  assign bus.EX_Rs              = r_rs;
  assign bus.EX_Rt              = r_rt;
  assign bus.EX_Rd              = r_rd;
  assign bus.HazardStall        = w_hazard;
  assign bus.BubbleCount        = r_bubbles;

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of PC, register-read and immediate datapaths, SHALL be honoured.
REQ-002 Parameter REG_W, default 5, width of register specifiers, SHALL be honoured.
REQ-003 Parameter WB_W, default 4, width of write-back control field, SHALL be honoured.
REQ-004 Parameter MEM_W, default 5, width of memory control field, SHALL be honoured.
REQ-005 Parameter MEMREAD_BIT, default 0, index of load-enable bit within MEM control, SHALL be honoured.
REQ-006 Parameter CNT_W, default 16, width of bubble counter, SHALL be honoured.
REQ-007 Ports SHALL be: Clk in 1 clock; Rst_n in 1 reset.
REQ-008 Ports SHALL be: Stall in 1 hold all EX contents; Flush in 1 squash ID-to-EX transfer; ID_Valid in 1 ID holds a real instruction.
REQ-009 Ports SHALL be: ID_WB_Ctrl in WB_W; ID_MEM_Ctrl in MEM_W; ID_EX_Ctrl in 9, [1:0] RegDst, [2] ALUSrc, [6:3] ALUOp, [8:7] HalfByte.
REQ-010 Ports SHALL be: ID_PCAddResult, ID_Read1, ID_Read2, ID_SignExtend, ID_SignExtend_10_6 in DATA_W; ID_Rs, ID_Rt, ID_Rd in REG_W.
REQ-011 Outputs SHALL be registered EX_ copies of every REQ-010 field, plus EX_WBCtrl WB_W, EX_MEMCtrl MEM_W, EX_RegDst 2, EX_ALUSrc 1, EX_ALUOp 4, EX_HalfByte 2, EX_Valid 1.
REQ-012 Outputs SHALL include HazardStall out 1 (combinational load-use stall request to PC/IF-ID) and BubbleCount out CNT_W.
REQ-013 Clocking SHALL be one clock, Clk, all state on its rising edge; reset SHALL be synchronous and active-low on Rst_n.

Function
REQ-014 HazardStall SHALL equal EX_Valid & EX_MEMCtrl[MEMREAD_BIT] & ID_Valid & (EX_Rt != 0) & (EX_Rt == ID_Rs | EX_Rt == ID_Rt).
REQ-015 Per rising edge, action priority SHALL be: reset > Flush > Stall > HazardStall > load.
REQ-016 Flush SHALL clear EX_Valid, EX_WBCtrl, EX_MEMCtrl and all EX_Ctrl-derived outputs; datapath outputs keep prior values.
REQ-017 Stall (without Flush) SHALL hold every EX_ output and EX_Valid unchanged.
REQ-018 HazardStall (no Flush, no Stall) SHALL insert a bubble: same clearing as REQ-016.
REQ-019 Load SHALL copy all ID_ fields to EX_ outputs with one-cycle latency; EX_Valid <= ID_Valid.
REQ-020 Load with ID_Valid=0 SHALL force control outputs to zero as in REQ-016.
REQ-021 BubbleCount SHALL increment by 1 on each edge where REQ-018 applies, saturating at 2^CNT_W-1 without wrap.
REQ-022 Flush or Stall coincident with HazardStall SHALL NOT increment BubbleCount.
REQ-023 Register specifier 0 SHALL never trigger HazardStall.
REQ-024 HazardStall SHALL deassert the cycle after a bubble since EX_Valid is then 0.

Reset
REQ-025 With Rst_n=0 at a rising edge, all EX_ outputs, EX_Valid and BubbleCount SHALL become 0.
REQ-026 Reset SHALL override Flush, Stall and HazardStall; HazardStall SHALL read 0 the cycle after reset.
REQ-027 Reset asserted mid-stall SHALL discard held contents; first post-reset edge performs normal load.

Verification
REQ-028 Load: ID_Valid=1, ID_Read1=0x12345678, ID_EX_Ctrl=0x1A5 -> next edge EX_Read1=0x12345678, EX_RegDst=1, EX_ALUSrc=1, EX_ALUOp=4, EX_HalfByte=3, EX_Valid=1.
REQ-029 Load-use: EX holds load (MEMCtrl[0]=1) with EX_Rt=8, ID_Rs=8 -> HazardStall=1, next edge EX_Valid=0, EX_MEMCtrl=0, BubbleCount=1, HazardStall=0.
REQ-030 Zero register: EX load EX_Rt=0, ID_Rs=0 -> HazardStall=0, normal load.
REQ-031 Stall 3 cycles while ID inputs change -> EX outputs constant; Stall+Flush same edge -> EX_Valid=0.
REQ-032 Saturation: CNT_W=2, five consecutive bubbles -> BubbleCount 1,2,3,3,3.
REQ-033 Rst_n=0 during Stall with EX_Valid=1 -> next edge all outputs 0; release -> following edge loads ID values.
